// File: rtl/jtframe_sdram_rq_pkg.sv
// Shared helpers for the SDRAM request adapter: client-to-SDRAM address scaling
// and lane selection out of a 32-bit SDRAM line.
package jtframe_sdram_rq_pkg;

    localparam int LINEW = 32;

    // Client units are DW bits wide, SDRAM words are 16 bits wide
    function automatic logic [LINEW-1:0] scale_addr(input logic [LINEW-1:0] addr, input int dw);
        case (dw)
            8:       return addr >> 1;
            32:      return addr << 1;
            default: return addr;
        endcase
    endfunction

    function automatic logic [LINEW-1:0] lane_sel(input logic [LINEW-1:0] din, input int dw,
                                                 input logic wsel, input logic bsel);
        logic [15:0] word;
        word = wsel ? din[31:16] : din[15:0];
        case (dw)
            8:       return {24'd0, (bsel ? word[15:8] : word[7:0])};
            16:      return {16'd0, word};
            default: return din;
        endcase
    endfunction

endpackage

// File: rtl/jtframe_sdram_rq_if.sv
// Client + arbiter signal bundle for one SDRAM slot; the adapter uses the slave view.
interface jtframe_sdram_rq_if #(
    parameter int SDRAMW = 22,
    parameter int AW     = 8,
    parameter int DW     = 8
);
    logic              clr;
    logic [SDRAMW-1:0] offset;
    logic [AW-1:0]     addr;
    logic              addr_ok;
    logic              wrin;
    logic [DW-1:0]     wrdata;
    logic              req_rnw;
    logic [SDRAMW-1:0] sdram_addr;
    logic [31:0]       din;
    logic              din_ok;
    logic [DW-1:0]     dout;
    logic              req;
    logic              data_ok;
    logic              we;

    modport slave (
        input  clr, offset, addr, addr_ok, wrin, wrdata, din, din_ok, we,
        output req_rnw, sdram_addr, dout, req, data_ok
    );

    modport master (
        output clr, offset, addr, addr_ok, wrin, wrdata, din, din_ok, we,
        input  req_rnw, sdram_addr, dout, req, data_ok
    );
endinterface

// File: rtl/jtframe_sdram_rq_line.sv
// Single 32-bit cache line: valid bit, line-address tag and data, with hit compare.
module jtframe_rq_line #(
    parameter int SDRAMW = 22
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clr,
    input  logic              i_capture,
    input  logic [SDRAMW-1:0] i_tag,
    input  logic [31:0]       i_din,
    output logic              o_hit,
    output logic [31:0]       o_data
);
    logic              r_valid;
    logic [SDRAMW-1:0] r_tag;
    logic [31:0]       r_data;

    // Invalidation takes priority over a fill landing on the same edge
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_tag   <= '0;
            r_data  <= '0;
        end else if (i_clr) begin
            r_valid <= 1'b0;
        end else if (i_capture) begin
            r_valid <= 1'b1;
            r_tag   <= i_tag;
            r_data  <= i_din;
        end
    end

    assign o_hit  = r_valid && (r_tag == i_tag);
    assign o_data = r_data;
endmodule

// File: rtl/jtframe_sdram_rq.sv
// Per-slot SDRAM request adapter: ROM mode caches one 32-bit line, RAM mode
// issues one read/write access per client access.
module jtframe_sdram_rq
    import jtframe_sdram_rq_pkg::*;
#(
    parameter int SDRAMW = 22,
    parameter int AW     = 8,
    parameter int DW     = 8,
    parameter int WRITE  = 0,
    parameter int LATCH  = 0
) (
    input logic               clk,
    input logic               rst,
    jtframe_sdram_rq_if.slave bus
);
    logic [SDRAMW-1:0] w_addr;
    logic              w_capture;

    assign w_addr         = bus.offset + SDRAMW'(scale_addr(LINEW'(bus.addr), DW));
    assign w_capture      = bus.din_ok & bus.we;
    assign bus.sdram_addr = w_addr;

    generate
        if (WRITE == 0) begin : g_rom
            logic [SDRAMW-1:0] w_tag;
            logic              w_hit;
            logic [31:0]       w_line;
            logic [DW-1:0]     w_dout;
            logic              w_data_ok;

            // Narrow clients share a two-word line, so the tag ignores the word bit
            assign w_tag = (DW == 32) ? w_addr : {w_addr[SDRAMW-1:1], 1'b0};

            jtframe_rq_line #(.SDRAMW(SDRAMW)) u_line (
                .i_clk     (clk),
                .i_rst     (rst),
                .i_clr     (bus.clr),
                .i_capture (w_capture),
                .i_tag     (w_tag),
                .i_din     (bus.din),
                .o_hit     (w_hit),
                .o_data    (w_line)
            );

            assign w_dout      = DW'(lane_sel(w_line, DW, w_addr[0], bus.addr[0]));
            assign w_data_ok   = bus.addr_ok & w_hit;
            assign bus.req     = bus.addr_ok & ~w_hit;
            assign bus.req_rnw = 1'b1;

            if (LATCH != 0) begin : g_latch
                logic          r_data_ok;
                logic [DW-1:0] r_dout;

                always_ff @(posedge clk) begin
                    if (rst) begin
                        r_data_ok <= 1'b0;
                        r_dout    <= '0;
                    end else begin
                        r_data_ok <= w_data_ok;
                        r_dout    <= w_dout;
                    end
                end

                assign bus.data_ok = r_data_ok;
                assign bus.dout    = r_dout;
            end else begin : g_comb
                assign bus.data_ok = w_data_ok;
                assign bus.dout    = w_dout;
            end
        end else begin : g_ram
            logic          r_done;
            logic [AW-1:0] r_addr;
            logic          r_wrin;
            logic [DW-1:0] r_dout;
            logic          w_same;
            logic          w_done;

            // A stale done must never acknowledge a different access, even for one cycle
            assign w_same = (bus.addr == r_addr) && (bus.wrin == r_wrin);
            assign w_done = r_done & bus.addr_ok & w_same;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_done <= 1'b0;
                    r_addr <= '0;
                    r_wrin <= 1'b0;
                    r_dout <= '0;
                end else begin
                    if (!w_done) begin
                        r_addr <= bus.addr;
                        r_wrin <= bus.wrin;
                    end
                    if (!bus.addr_ok)
                        r_done <= 1'b0;
                    else if (w_capture)
                        r_done <= 1'b1;
                    else if (!w_same)
                        r_done <= 1'b0;
                    if (w_capture && !bus.wrin)
                        r_dout <= DW'(lane_sel(bus.din, DW, 1'b0, bus.addr[0]));
                end
            end

            assign bus.req     = bus.addr_ok & ~w_done;
            assign bus.data_ok = w_done;
            assign bus.dout    = r_dout;
            assign bus.req_rnw = ~bus.wrin;
        end
    endgenerate
endmodule

// File: tb/tb_jtframe_sdram_rq.sv
// Self-checking bench: ROM DW=8 (with and without LATCH), RAM DW=16 and ROM DW=32
// slots, driven by directed sequences and randomized traffic against a behavioural model.
module tb_jtframe_sdram_rq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    jtframe_sdram_rq_if #(.SDRAMW(22), .AW(8), .DW(8))  if_r8  ();
    jtframe_sdram_rq_if #(.SDRAMW(22), .AW(8), .DW(8))  if_r8l ();
    jtframe_sdram_rq_if #(.SDRAMW(22), .AW(8), .DW(16)) if_ram ();
    jtframe_sdram_rq_if #(.SDRAMW(22), .AW(8), .DW(32)) if_r32 ();

    jtframe_sdram_rq #(.SDRAMW(22), .AW(8), .DW(8), .WRITE(0), .LATCH(0))
        u_r8 (.clk(clk), .rst(rst), .bus(if_r8));
    jtframe_sdram_rq #(.SDRAMW(22), .AW(8), .DW(8), .WRITE(0), .LATCH(1))
        u_r8l (.clk(clk), .rst(rst), .bus(if_r8l));
    jtframe_sdram_rq #(.SDRAMW(22), .AW(8), .DW(16), .WRITE(1), .LATCH(0))
        u_ram (.clk(clk), .rst(rst), .bus(if_ram));
    jtframe_sdram_rq #(.SDRAMW(22), .AW(8), .DW(32), .WRITE(0), .LATCH(0))
        u_r32 (.clk(clk), .rst(rst), .bus(if_r32));

    // Both DW=8 ROM slots see identical stimulus so LATCH timing can be compared
    logic        r8_clr, r8_aok, r8_dok, r8_we;
    logic [21:0] r8_off;
    logic [7:0]  r8_addr;
    logic [31:0] r8_din;

    assign if_r8.clr      = r8_clr;   assign if_r8l.clr     = r8_clr;
    assign if_r8.offset   = r8_off;   assign if_r8l.offset  = r8_off;
    assign if_r8.addr     = r8_addr;  assign if_r8l.addr    = r8_addr;
    assign if_r8.addr_ok  = r8_aok;   assign if_r8l.addr_ok = r8_aok;
    assign if_r8.din      = r8_din;   assign if_r8l.din     = r8_din;
    assign if_r8.din_ok   = r8_dok;   assign if_r8l.din_ok  = r8_dok;
    assign if_r8.we       = r8_we;    assign if_r8l.we      = r8_we;
    assign if_r8.wrin     = 1'b0;     assign if_r8l.wrin    = 1'b0;
    assign if_r8.wrdata   = 8'd0;     assign if_r8l.wrdata  = 8'd0;

    logic [15:0] ram_mem [int];
    int          ram_prev_addr;
    int          ram_prev_wr;
    logic [15:0] ram_last;

    function automatic logic [15:0] memw(input logic [21:0] a);
        return 16'(a * 22'd40503) ^ 16'h5A3C;
    endfunction

    function automatic logic [15:0] rd(input int a);
        if (ram_mem.exists(a)) return ram_mem[a];
        return memw(22'(a));
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        r8_clr = 0; r8_aok = 0; r8_dok = 0; r8_we = 0; r8_off = '0; r8_addr = '0; r8_din = '0;
        if_ram.clr = 0; if_ram.offset = '0; if_ram.addr = '0; if_ram.addr_ok = 0; if_ram.wrin = 0;
        if_ram.wrdata = '0; if_ram.din = '0; if_ram.din_ok = 0; if_ram.we = 0;
        if_r32.clr = 0; if_r32.offset = '0; if_r32.addr = '0; if_r32.addr_ok = 0; if_r32.wrin = 0;
        if_r32.wrdata = '0; if_r32.din = '0; if_r32.din_ok = 0; if_r32.we = 0;
        rst = 1;
        step(); step();
        rst = 0;
        #1;
        tests++; if (if_r8.req !== 1'b0) begin fails++; $display("[TB] FAIL reset r8 req: got %b want 0", if_r8.req); end
        tests++; if (if_r8.data_ok !== 1'b0) begin fails++; $display("[TB] FAIL reset r8 data_ok: got %b want 0", if_r8.data_ok); end
        tests++; if (if_r8l.dout !== 8'h00) begin fails++; $display("[TB] FAIL reset r8l dout: got %h want 00", if_r8l.dout); end
        tests++; if (if_ram.data_ok !== 1'b0) begin fails++; $display("[TB] FAIL reset ram data_ok: got %b want 0", if_ram.data_ok); end
        tests++; if (if_ram.dout !== 16'h0000) begin fails++; $display("[TB] FAIL reset ram dout: got %h want 0000", if_ram.dout); end
    endtask

    task automatic test_rom_fill();
        r8_off = 22'h100; r8_addr = 8'd5; r8_aok = 1;
        #1;
        tests++; if (if_r8.sdram_addr !== 22'h102) begin fails++; $display("[TB] FAIL fill sdram_addr: got %h want 102", if_r8.sdram_addr); end
        tests++; if (if_r8.req !== 1'b1) begin fails++; $display("[TB] FAIL fill req before: got %b want 1", if_r8.req); end
        tests++; if (if_r8.req_rnw !== 1'b1) begin fails++; $display("[TB] FAIL fill req_rnw: got %b want 1", if_r8.req_rnw); end
        r8_din = 32'hAABBCCDD; r8_dok = 1; r8_we = 1;
        step();
        r8_dok = 0; r8_we = 0;
        #1;
        tests++; if (if_r8.req !== 1'b0) begin fails++; $display("[TB] FAIL fill req after: got %b want 0", if_r8.req); end
        tests++; if (if_r8.data_ok !== 1'b1) begin fails++; $display("[TB] FAIL fill data_ok: got %b want 1", if_r8.data_ok); end
        tests++; if (if_r8.dout !== 8'hCC) begin fails++; $display("[TB] FAIL fill dout: got %h want cc", if_r8.dout); end
        tests++; if (if_r8l.data_ok !== 1'b0) begin fails++; $display("[TB] FAIL latch data_ok early: got %b want 0", if_r8l.data_ok); end
        tests++; if (if_r8l.req !== 1'b0) begin fails++; $display("[TB] FAIL latch req: got %b want 0", if_r8l.req); end
        step();
        tests++; if (if_r8l.data_ok !== 1'b1) begin fails++; $display("[TB] FAIL latch data_ok late: got %b want 1", if_r8l.data_ok); end
        tests++; if (if_r8l.dout !== 8'hCC) begin fails++; $display("[TB] FAIL latch dout: got %h want cc", if_r8l.dout); end
    endtask

    task automatic test_rom_hit_miss();
        r8_addr = 8'd4;
        #1;
        tests++; if (if_r8.dout !== 8'hDD) begin fails++; $display("[TB] FAIL hit dout: got %h want dd", if_r8.dout); end
        tests++; if (if_r8.req !== 1'b0) begin fails++; $display("[TB] FAIL hit req: got %b want 0", if_r8.req); end
        r8_addr = 8'd8;
        #1;
        tests++; if (if_r8.req !== 1'b1) begin fails++; $display("[TB] FAIL miss req: got %b want 1", if_r8.req); end
        tests++; if (if_r8.sdram_addr !== 22'h104) begin fails++; $display("[TB] FAIL miss sdram_addr: got %h want 104", if_r8.sdram_addr); end
        tests++; if (if_r8.data_ok !== 1'b0) begin fails++; $display("[TB] FAIL miss data_ok: got %b want 0", if_r8.data_ok); end
    endtask

    task automatic test_clr();
        r8_addr = 8'd4; r8_clr = 1;
        step();
        r8_clr = 0;
        #1;
        tests++; if (if_r8.req !== 1'b1) begin fails++; $display("[TB] FAIL clr req: got %b want 1", if_r8.req); end
        r8_din = 32'h11223344; r8_dok = 1; r8_we = 1; r8_clr = 1;
        step();
        r8_dok = 0; r8_we = 0; r8_clr = 0;
        #1;
        tests++; if (if_r8.req !== 1'b1) begin fails++; $display("[TB] FAIL clr+capture req: got %b want 1", if_r8.req); end
        tests++; if (if_r8.data_ok !== 1'b0) begin fails++; $display("[TB] FAIL clr+capture data_ok: got %b want 0", if_r8.data_ok); end
    endtask

    task automatic test_no_we();
        r8_din = 32'h55667788; r8_dok = 1; r8_we = 0;
        step();
        r8_dok = 0;
        #1;
        tests++; if (if_r8.req !== 1'b1) begin fails++; $display("[TB] FAIL no_we req: got %b want 1", if_r8.req); end
        tests++; if (if_r8.data_ok !== 1'b0) begin fails++; $display("[TB] FAIL no_we data_ok: got %b want 0", if_r8.data_ok); end
    endtask

    task automatic test_rom_random();
        bit          m_valid, prev_dok, hit, ereq, edok;
        int unsigned m_line, sa, line;
        logic [31:0] m_data;
        logic [7:0]  prev_dout, edout;
        r8_off = 22'($urandom_range(0, 4000));
        r8_aok = 0; r8_clr = 1; r8_dok = 0; r8_we = 0;
        step();
        r8_clr = 0;
        step();
        m_valid = 0; m_line = 0; m_data = '0; prev_dok = 0; prev_dout = '0;
        for (int i = 0; i < 80; i++) begin
            r8_addr = 8'($urandom_range(0, 15));
            r8_aok  = ($urandom_range(0, 9) != 0);
            r8_clr  = ($urandom_range(0, 11) == 0);
            sa   = (int'(r8_off) + int'(r8_addr) / 2) % (1 << 22);
            line = sa - (sa % 2);
            hit  = m_valid && (m_line == line);
            ereq = r8_aok && !hit;
            edok = r8_aok && hit;
            edout = 8'(m_data >> (8 * ((sa % 2) * 2 + (int'(r8_addr) % 2))));
            r8_dok = 0; r8_we = 0;
            if (ereq && $urandom_range(0, 1) == 1) begin
                r8_dok = 1; r8_we = 1;
                r8_din = {memw(22'(line + 1)), memw(22'(line))};
            end else if ($urandom_range(0, 3) == 0) begin
                r8_dok = 1;
                r8_din = $urandom;
            end
            #1;
            tests++; if (if_r8.sdram_addr !== 22'(sa)) begin fails++; $display("[TB] FAIL rnd sdram_addr: got %h want %h", if_r8.sdram_addr, 22'(sa)); end
            tests++; if (if_r8.req !== ereq) begin fails++; $display("[TB] FAIL rnd req: got %b want %b", if_r8.req, ereq); end
            tests++; if (if_r8.data_ok !== edok) begin fails++; $display("[TB] FAIL rnd data_ok: got %b want %b", if_r8.data_ok, edok); end
            if (edok) begin
                tests++; if (if_r8.dout !== edout) begin fails++; $display("[TB] FAIL rnd dout: got %h want %h", if_r8.dout, edout); end
            end
            tests++; if (if_r8l.data_ok !== prev_dok) begin fails++; $display("[TB] FAIL rnd latch data_ok: got %b want %b", if_r8l.data_ok, prev_dok); end
            if (prev_dok) begin
                tests++; if (if_r8l.dout !== prev_dout) begin fails++; $display("[TB] FAIL rnd latch dout: got %h want %h", if_r8l.dout, prev_dout); end
            end
            prev_dok = edok; prev_dout = edout;
            if (r8_clr) m_valid = 0;
            else if (r8_dok && r8_we) begin m_valid = 1; m_line = line; m_data = r8_din; end
            step();
        end
        r8_aok = 0; r8_clr = 0; r8_dok = 0; r8_we = 0;
    endtask

    task automatic test_ram_directed();
        if_ram.offset = 22'h10; if_ram.addr = 8'd3; if_ram.wrin = 1; if_ram.wrdata = 16'h1234; if_ram.addr_ok = 1;
        #1;
        tests++; if (if_ram.req !== 1'b1) begin fails++; $display("[TB] FAIL ram wr req: got %b want 1", if_ram.req); end
        tests++; if (if_ram.req_rnw !== 1'b0) begin fails++; $display("[TB] FAIL ram wr req_rnw: got %b want 0", if_ram.req_rnw); end
        tests++; if (if_ram.sdram_addr !== 22'h13) begin fails++; $display("[TB] FAIL ram sdram_addr: got %h want 13", if_ram.sdram_addr); end
        if_ram.din = 32'hDEAD0000; if_ram.din_ok = 1; if_ram.we = 1;
        step();
        if_ram.din_ok = 0; if_ram.we = 0;
        #1;
        tests++; if (if_ram.data_ok !== 1'b1) begin fails++; $display("[TB] FAIL ram wr data_ok: got %b want 1", if_ram.data_ok); end
        tests++; if (if_ram.req !== 1'b0) begin fails++; $display("[TB] FAIL ram wr req after: got %b want 0", if_ram.req); end
        tests++; if (if_ram.dout !== 16'h0000) begin fails++; $display("[TB] FAIL ram wr dout held: got %h want 0000", if_ram.dout); end
        ram_mem[32'h13] = 16'h1234;
        if_ram.addr_ok = 0;
        step();
        if_ram.addr_ok = 1; if_ram.wrin = 0;
        #1;
        tests++; if (if_ram.req !== 1'b1) begin fails++; $display("[TB] FAIL ram rd req: got %b want 1", if_ram.req); end
        tests++; if (if_ram.req_rnw !== 1'b1) begin fails++; $display("[TB] FAIL ram rd req_rnw: got %b want 1", if_ram.req_rnw); end
        if_ram.din = {rd(32'h14), rd(32'h13)}; if_ram.din_ok = 1; if_ram.we = 1;
        step();
        if_ram.din_ok = 0; if_ram.we = 0;
        #1;
        tests++; if (if_ram.dout !== 16'h1234) begin fails++; $display("[TB] FAIL ram rd dout: got %h want 1234", if_ram.dout); end
        tests++; if (if_ram.data_ok !== 1'b1) begin fails++; $display("[TB] FAIL ram rd data_ok: got %b want 1", if_ram.data_ok); end
        ram_last = 16'h1234; ram_prev_addr = 3; ram_prev_wr = 0;
    endtask

    task automatic test_ram_random();
        int a, wr, lat, sa;
        bit drop;
        logic [15:0] wd;
        if_ram.offset = 22'($urandom_range(0, 30000));
        for (int i = 0; i < 24; i++) begin
            a  = $urandom_range(0, 31);
            wr = $urandom_range(0, 1);
            wd = 16'($urandom);
            drop = ($urandom_range(0, 1) == 1) || (a == ram_prev_addr && wr == ram_prev_wr);
            if (drop) begin
                if_ram.addr_ok = 0;
                #1;
                tests++; if (if_ram.data_ok !== 1'b0) begin fails++; $display("[TB] FAIL ram drop data_ok: got %b want 0", if_ram.data_ok); end
                step();
            end
            sa = (int'(if_ram.offset) + a) % (1 << 22);
            if_ram.addr = 8'(a); if_ram.wrin = wr[0]; if_ram.wrdata = wd; if_ram.addr_ok = 1;
            lat = $urandom_range(0, 3);
            for (int k = 0; k < lat; k++) begin
                if_ram.din_ok = ($urandom_range(0, 2) == 0); if_ram.we = 0; if_ram.din = $urandom;
                #1;
                tests++; if (if_ram.req !== 1'b1) begin fails++; $display("[TB] FAIL ram wait req: got %b want 1", if_ram.req); end
                tests++; if (if_ram.data_ok !== 1'b0) begin fails++; $display("[TB] FAIL ram wait data_ok: got %b want 0", if_ram.data_ok); end
                tests++; if (if_ram.req_rnw !== ~wr[0]) begin fails++; $display("[TB] FAIL ram req_rnw: got %b want %b", if_ram.req_rnw, ~wr[0]); end
                tests++; if (if_ram.sdram_addr !== 22'(sa)) begin fails++; $display("[TB] FAIL ram rnd sdram_addr: got %h want %h", if_ram.sdram_addr, 22'(sa)); end
                step();
            end
            if_ram.din = wr ? $urandom : {rd(sa + 1), rd(sa)};
            if_ram.din_ok = 1; if_ram.we = 1;
            #1;
            tests++; if (if_ram.req !== 1'b1) begin fails++; $display("[TB] FAIL ram ack req: got %b want 1", if_ram.req); end
            step();
            if_ram.din_ok = 0; if_ram.we = 0;
            if (wr == 0) ram_last = rd(sa);
            else ram_mem[sa] = wd;
            #1;
            tests++; if (if_ram.data_ok !== 1'b1) begin fails++; $display("[TB] FAIL ram done data_ok: got %b want 1", if_ram.data_ok); end
            tests++; if (if_ram.req !== 1'b0) begin fails++; $display("[TB] FAIL ram done req: got %b want 0", if_ram.req); end
            tests++; if (if_ram.dout !== ram_last) begin fails++; $display("[TB] FAIL ram dout: got %h want %h", if_ram.dout, ram_last); end
            ram_prev_addr = a; ram_prev_wr = wr;
        end
        if_ram.addr_ok = 0;
    endtask

    task automatic test_dw32_reset();
        logic [31:0] d;
        d = $urandom;
        if_r32.offset = '0; if_r32.addr = 8'd2; if_r32.addr_ok = 1;
        #1;
        tests++; if (if_r32.sdram_addr !== 22'd4) begin fails++; $display("[TB] FAIL dw32 sdram_addr: got %h want 4", if_r32.sdram_addr); end
        tests++; if (if_r32.req !== 1'b1) begin fails++; $display("[TB] FAIL dw32 req: got %b want 1", if_r32.req); end
        if_r32.din = d; if_r32.din_ok = 1; if_r32.we = 1;
        step();
        if_r32.din_ok = 0; if_r32.we = 0;
        #1;
        tests++; if (if_r32.data_ok !== 1'b1) begin fails++; $display("[TB] FAIL dw32 data_ok: got %b want 1", if_r32.data_ok); end
        tests++; if (if_r32.dout !== d) begin fails++; $display("[TB] FAIL dw32 dout: got %h want %h", if_r32.dout, d); end
        if_r32.addr = 8'd3;
        #1;
        tests++; if (if_r32.sdram_addr !== 22'd6) begin fails++; $display("[TB] FAIL dw32 next sdram_addr: got %h want 6", if_r32.sdram_addr); end
        tests++; if (if_r32.req !== 1'b1) begin fails++; $display("[TB] FAIL dw32 next req: got %b want 1", if_r32.req); end
        rst = 1;
        step();
        rst = 0;
        if_r32.addr = 8'd2;
        #1;
        tests++; if (if_r32.data_ok !== 1'b0) begin fails++; $display("[TB] FAIL dw32 reset data_ok: got %b want 0", if_r32.data_ok); end
        tests++; if (if_r32.dout !== 32'd0) begin fails++; $display("[TB] FAIL dw32 reset dout: got %h want 0", if_r32.dout); end
        tests++; if (if_r32.req !== 1'b1) begin fails++; $display("[TB] FAIL dw32 reset cache: req got %b want 1", if_r32.req); end
    endtask

    initial begin
        test_reset();
        test_rom_fill();
        test_rom_hit_miss();
        test_clr();
        test_no_we();
        test_rom_random();
        test_ram_directed();
        test_ram_random();
        test_dw32_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
